alu_share_arbiter: RTL
======================

# alu_share_arbiter

Controller that shares one 4-bit add/subtract ALU between two requesters. Each requester presents an op and two 4-bit operands with a valid/ready handshake. The block arbitrates round-robin, latches the winning operands, drives the shared ALU for one cycle, and returns the registered result with the requester ID on a response handshake. It sits between the two operand sources and the combinational ALU datapath.

## Interface
Parameters:
- `WIDTH`, 4, operand/result width; must match the ALU width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i is requester i.
- `req_ready`  out  2  per-requester accept; at most one bit high.
- `req_op0`, `req_op1`  in  1  requester op: 0 = add, 1 = subtract.
- `req_a0`, `req_a1`  in  WIDTH  first operand.
- `req_b0`, `req_b1`  in  WIDTH  second operand.
- `alu_op`  out  1  op driven to the shared ALU.
- `alu_r1`, `alu_r2`  out  WIDTH  operands driven to the shared ALU.
- `alu_result`  in  WIDTH  combinational ALU result.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  1  requester that issued the response.
- `rsp_result`  out  WIDTH  registered ALU result.

## Operation
- FSM states: IDLE, EXEC, HOLD.
- IDLE: grant is combinational from `req_valid` and `last_id`. If exactly one bit is valid, that requester wins. If both are valid, requester `~last_id` wins. `req_ready[grant]` = 1 only in IDLE with a valid request. On the handshake (valid & ready), latch op/a/b/id, update `last_id` to the granted id, and go to EXEC.
- EXEC: `alu_op/alu_r1/alu_r2` are driven from the latched registers. At the end of the cycle, capture `alu_result` into `rsp_result`, set `rsp_valid`, and go to HOLD.
- HOLD: `rsp_valid`, `rsp_id` and `rsp_result` are held stable until `rsp_ready`=1. On the handshake, clear `rsp_valid` and go to IDLE.
- Outside EXEC, `alu_*` keep the last latched values (no glitch-driven toggling); they are not meaningful.
- Arithmetic: results are modulo 2^WIDTH. Subtract = a − b two's complement, wrapping (for example 2 − 5 = 4'hD). No carry/overflow output.
- Requests are never accepted outside IDLE. Requesters must hold valid and operands stable until ready.
- Reset mid-operation: the FSM returns to IDLE immediately, any latched request or pending response is discarded, and `last_id` is reset.

## Timing
- Reset values: state=IDLE, `req_ready`=2'b00 (with no valid), `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `alu_op`=0, `alu_r1`=`alu_r2`=0, `last_id`=1 (requester 0 wins the first tie).
- Latency: accept in cycle N, EXEC in N+1, `rsp_valid` high from N+2.
- Maximum throughput: one op per 3 cycles with `rsp_ready` tied high (accept N, respond N+2, next accept N+3).
- A `rsp_ready` stall extends HOLD indefinitely. Both requesters then see `req_ready`=0.
- `req_ready` depends combinationally on `req_valid`. `rsp_valid` is registered.

## Configuration
- Macro `ALU_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority; requester 0 always wins when both are valid. `last_id` is still tracked but ignored.
- Undefined (default): round-robin as described in Operation.

## Structure
- Shared package `alu_arb_pkg`:
  - FSM state enum (IDLE, EXEC, HOLD).
  - Op encodings `OP_ADD`=0, `OP_SUB`=1.
  - Default `WIDTH`.
- Sub-module `rr_arbiter_two`: combinational 2-way grant from `req_valid`, `last_id` and `enable` (state==IDLE). The fixed-priority macro is applied inside it.
- The ALU itself is external to this block.

## Test plan
- Single request: req0 add a=3, b=4 -> `req_ready[0]` in the same cycle; `rsp_valid` two cycles later with `rsp_id`=0, `rsp_result`=7.
- Wrap cases:
  - req1 sub a=2, b=5 -> `rsp_result`=4'hD, `rsp_id`=1.
  - add a=9, b=9 -> 4'h2.
- Both valid continuously with `rsp_ready`=1 -> grants alternate 0,1,0,1…, accepts spaced 3 cycles apart. With `ALU_ARB_FIXED_PRIO_EN` -> always 0.
- Response stall: hold `rsp_ready`=0 for 5 cycles -> `rsp_valid`/`rsp_result`/`rsp_id` stable, `req_ready`=0 throughout; accept resumes the cycle after the response handshake.
- Reset asserted during EXEC -> outputs return to reset values asynchronously; after release, no stale response appears and the first tie goes to requester 0.
- Requester drops valid before grant (valid only while ready is 0, during HOLD) -> no acceptance, and no response for that requester.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU share arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned WIDTH_DEF = 4;

endpackage

// File: rtl/rr_arbiter_two.sv
// Combinational 2-way grant: round-robin on ties, or fixed priority to
// requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter_two (
  input  logic [1:0] req_valid_i,
  input  logic       last_id_i,
  input  logic       enable_i,
  output logic [1:0] grant_o,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_id;
  assign unused_last_id = last_id_i;
`endif

  always_comb begin
    grant_valid_o = enable_i && (req_valid_i != 2'b00);
    grant_id_o    = 1'b0;
    if (req_valid_i == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_id_o = 1'b0;
`else
      grant_id_o = ~last_id_i;
`endif
    end else begin
      grant_id_o = req_valid_i[1];
    end
    grant_o = 2'b00;
    if (grant_valid_o) begin
      grant_o = grant_id_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external add/sub ALU between two valid/ready requesters.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed priority to requester 0).
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic             req_op0,
  input  logic             req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic             alu_op,
  output logic [WIDTH-1:0] alu_r1,
  output logic [WIDTH-1:0] alu_r2,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result
);

  state_e           state_q;
  logic             last_id_q;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;

  logic [1:0]       grant;
  logic             grant_valid;
  logic             grant_id;
  logic             op_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;

  rr_arbiter_two u_arb (
    .req_valid_i   (req_valid),
    .last_id_i     (last_id_q),
    .enable_i      (state_q == ST_IDLE),
    .grant_o       (grant),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  always_comb begin
    op_d = grant_id ? req_op1 : req_op0;
    a_d  = grant_id ? req_a1  : req_a0;
    b_d  = grant_id ? req_b1  : req_b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_id_q    <= 1'b1;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= grant_id;
            last_id_q <= grant_id;
            state_q   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result_q <= alu_result;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ALU operands come straight from the latch registers so they only move on accept.
  assign req_ready  = grant;
  assign alu_op     = op_q;
  assign alu_r1     = a_q;
  assign alu_r2     = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule
